// File: rtl/sobel_edge_core.sv
// Streaming 3x3 Sobel edge detector with inferred line buffers and a fixed 4-stage pipeline.
// Optional per-frame edge counter output is enabled with the SOBEL_STATS_EN macro.
module sobel_edge_core #(
  parameter int PIC_W = 480,
  parameter int PIC_H = 272,
  parameter int DW    = 8,
  parameter int CW    = 12
) (
  input  logic          tft_clk,
  input  logic          tft_rst,
  input  logic          ip_flag,
  input  logic [DW-1:0] ip_data,
  input  logic          ip_sof,
  input  logic [1:0]    mode,
  input  logic [DW+1:0] thresh,
  output logic          op_flag,
  output logic [DW-1:0] op_data,
  output logic          op_sof,
  output logic          op_eol,
  output logic          frame_done
`ifdef SOBEL_STATS_EN
  ,
  output logic [2*CW-1:0] edge_cnt
`endif
);

  localparam int AW = $clog2(PIC_W);
  localparam logic [CW-1:0] COL_LAST = CW'(PIC_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(PIC_H - 1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] ZERO     = CW'(0);

  function automatic logic signed [DW+3:0] ext_f(input logic [DW-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  // Magnitude fits in DW+3 bits, so the low bits of the two's complement negation suffice.
  function automatic logic [DW+2:0] abs_f(input logic signed [DW+3:0] v);
    return v[DW+3] ? (~v[DW+2:0] + {{(DW+2){1'b0}}, 1'b1}) : v[DW+2:0];
  endfunction

  function automatic logic [DW-1:0] sat_f(input logic [DW+2:0] v);
    return (v[DW+2:DW] != 3'b000) ? {DW{1'b1}} : v[DW-1:0];
  endfunction

  logic [CW-1:0]   col_r, row_r, cur_col_s, cur_row_s;
  logic [AW-1:0]   addr_s;
  logic [1:0]      mode_f_r, mode1_r, mode2_r, mode3_r;
  logic [DW+1:0]   thresh_f_r, th1_r, th2_r;
  logic [DW-1:0]   lb0_r [PIC_W];
  logic [DW-1:0]   lb1_r [PIC_W];
  logic [DW-1:0]   tl_r, tc_r, tr_r, ml_r, mc_r, mr_r, bl_r, bc_r, br_r;
  logic            v1_r, v2_r, v3_r;
  logic            sof1_r, sof2_r, sof3_r, eol1_r, eol2_r, eol3_r, fd1_r, fd2_r, fd3_r;
  logic signed [DW+3:0] gx_s, gy_s, gx2_r, gy2_r;
  logic [DW+2:0]   ax_s, ay_s, sum_s, ax3_r, ay3_r, sum3_r;
  logic            ge3_r;
  logic [DW-1:0]   out_s;

  // Position of the pixel on the input bus; a qualified start-of-frame forces (0,0).
  always_comb begin
    cur_col_s = col_r;
    cur_row_s = row_r;
    if (ip_sof) begin
      cur_col_s = ZERO;
      cur_row_s = ZERO;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
  end

  assign addr_s = cur_col_s[AW-1:0];

  // Frame position counters and per-frame latch of mode/threshold.
  always_ff @(posedge tft_clk or posedge tft_rst) begin
    if (tft_rst) begin
      col_r      <= ZERO;
      row_r      <= ZERO;
      mode_f_r   <= 2'b00;
      thresh_f_r <= {(DW+2){1'b0}};
    end else if (ip_flag) begin
      if (cur_col_s == COL_LAST) begin
        col_r <= ZERO;
        row_r <= (cur_row_s == ROW_LAST) ? ZERO : cur_row_s + ONE;
      end else begin
        col_r <= cur_col_s + ONE;
        row_r <= cur_row_s;
      end
      if ((cur_col_s == ZERO) && (cur_row_s == ZERO)) begin
        mode_f_r   <= mode;
        thresh_f_r <= thresh;
      end
    end
  end

  // Line buffers (read-before-write) and the 3x3 window shift; no reset on storage.
  always_ff @(posedge tft_clk) begin
    if (ip_flag) begin
      lb0_r[addr_s] <= ip_data;
      lb1_r[addr_s] <= lb0_r[addr_s];
      tl_r <= tc_r;  tc_r <= tr_r;  tr_r <= lb1_r[addr_s];
      ml_r <= mc_r;  mc_r <= mr_r;  mr_r <= lb0_r[addr_s];
      bl_r <= bc_r;  bc_r <= br_r;  br_r <= ip_data;
    end
  end

  assign gx_s  = (ext_f(tr_r) + (ext_f(mr_r) <<< 1'b1) + ext_f(br_r))
               - (ext_f(tl_r) + (ext_f(ml_r) <<< 1'b1) + ext_f(bl_r));
  assign gy_s  = (ext_f(bl_r) + (ext_f(bc_r) <<< 1'b1) + ext_f(br_r))
               - (ext_f(tl_r) + (ext_f(tc_r) <<< 1'b1) + ext_f(tr_r));
  assign ax_s  = abs_f(gx2_r);
  assign ay_s  = abs_f(gy2_r);
  assign sum_s = ax_s + ay_s;

  // Output selection by the mode that was in force for this pixel's frame.
  always_comb begin
    out_s = {DW{1'b0}};
    case (mode3_r)
      2'b00:   out_s = sat_f(sum3_r);
      2'b01:   out_s = ge3_r ? {DW{1'b1}} : {DW{1'b0}};
      2'b10:   out_s = sat_f(ax3_r);
      2'b11:   out_s = sat_f(ay3_r);
      default: out_s = {DW{1'b0}};
    endcase
  end

  // Stages 1-4: valid/marker tracking, gradients, magnitudes, output register.
  always_ff @(posedge tft_clk or posedge tft_rst) begin
    if (tft_rst) begin
      v1_r <= 1'b0;  sof1_r <= 1'b0;  eol1_r <= 1'b0;  fd1_r <= 1'b0;
      v2_r <= 1'b0;  sof2_r <= 1'b0;  eol2_r <= 1'b0;  fd2_r <= 1'b0;
      v3_r <= 1'b0;  sof3_r <= 1'b0;  eol3_r <= 1'b0;  fd3_r <= 1'b0;
      mode1_r <= 2'b00;  mode2_r <= 2'b00;  mode3_r <= 2'b00;
      th1_r <= {(DW+2){1'b0}};  th2_r <= {(DW+2){1'b0}};
      gx2_r <= {(DW+4){1'b0}};  gy2_r <= {(DW+4){1'b0}};
      ax3_r <= {(DW+3){1'b0}};  ay3_r <= {(DW+3){1'b0}};  sum3_r <= {(DW+3){1'b0}};
      ge3_r <= 1'b0;
      op_flag <= 1'b0;  op_data <= {DW{1'b0}};
      op_sof  <= 1'b0;  op_eol  <= 1'b0;  frame_done <= 1'b0;
    end else begin
      v1_r    <= ip_flag && (cur_row_s >= TWO) && (cur_col_s >= TWO);
      sof1_r  <= (cur_row_s == TWO) && (cur_col_s == TWO);
      eol1_r  <= (cur_col_s == COL_LAST);
      fd1_r   <= (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
      mode1_r <= mode_f_r;
      th1_r   <= thresh_f_r;

      v2_r <= v1_r;  sof2_r <= sof1_r;  eol2_r <= eol1_r;  fd2_r <= fd1_r;
      mode2_r <= mode1_r;  th2_r <= th1_r;
      gx2_r <= gx_s;  gy2_r <= gy_s;

      v3_r <= v2_r;  sof3_r <= sof2_r;  eol3_r <= eol2_r;  fd3_r <= fd2_r;
      mode3_r <= mode2_r;
      ax3_r <= ax_s;  ay3_r <= ay_s;  sum3_r <= sum_s;
      ge3_r <= (sum_s >= {1'b0, th2_r});

      op_flag    <= v3_r;
      op_sof     <= v3_r && sof3_r;
      op_eol     <= v3_r && eol3_r;
      frame_done <= v3_r && fd3_r;
      op_data    <= v3_r ? out_s : {DW{1'b0}};
    end
  end

`ifdef SOBEL_STATS_EN
  logic [2*CW-1:0] acc_r;

  // Edge counter: counts S >= thresh per output pixel and publishes it with frame_done.
  always_ff @(posedge tft_clk or posedge tft_rst) begin
    if (tft_rst) begin
      acc_r    <= {(2*CW){1'b0}};
      edge_cnt <= {(2*CW){1'b0}};
    end else if (v3_r) begin
      if (fd3_r) begin
        edge_cnt <= acc_r + {{(2*CW-1){1'b0}}, ge3_r};
        acc_r    <= {(2*CW){1'b0}};
      end else begin
        acc_r    <= acc_r + {{(2*CW-1){1'b0}}, ge3_r};
      end
    end
  end
`endif

endmodule

// File: doc/sobel_edge_core.md
Name: sobel_edge_core

Overview:
Parametrised streaming 3x3 Sobel edge detector for the TFT video path. It sits between the grayscale converter and the display/frame writer, and uses internal inferred line buffers with no vendor FIFO IP. Output is selectable at run time between saturated magnitude, binary threshold, |Gx|-only and |Gy|-only. Frame position is tracked with an optional start-of-frame resync, and row/frame markers are produced for downstream blocks.

Parameters:
PIC_W, 480, active pixels per line (>=4)
PIC_H, 272, active lines per frame (>=4)
DW, 8, pixel bit width (4..12)
CW, 12, row/column counter width; must satisfy 2^CW > max(PIC_W, PIC_H)

Ports:
tft_clk  in  1  pixel clock; all logic is on its rising edge
tft_rst  in  1  asynchronous, active-high reset
ip_flag  in  1  input pixel valid; one pixel accepted per asserted cycle; gaps are allowed
ip_data  in  DW  input grayscale pixel
ip_sof  in  1  start of frame; meaningful only when ip_flag=1
mode  in  2  00 saturated |Gx|+|Gy|, 01 binary threshold, 10 |Gx| saturated, 11 |Gy| saturated
thresh  in  DW+2  binary threshold, compared against the unsaturated sum
op_flag  out  1  output pixel valid
op_data  out  DW  edge pixel
op_sof  out  1  qualifies the first output pixel of a frame
op_eol  out  1  qualifies the last output pixel of a row
frame_done  out  1  single-cycle pulse with the last output pixel of a frame

Behaviour:
- Reset: all outputs are 0, counters are 0 and window valid is cleared. Line-buffer RAM contents are not cleared; rows 0 and 1 refill them.
- Position counters col/row advance only on ip_flag.
  - col wraps at PIC_W-1, incrementing row.
  - row wraps at PIC_H-1 to 0.
- ip_flag & ip_sof: the current pixel is taken as (row 0, col 0) regardless of counter state. Any in-flight pipeline stages still drain.
- Two line buffers of depth PIC_W, width DW, addressed by col.
  - Read is registered.
  - Write of the incoming pixel happens in the same cycle, read-before-write.
- Window: a 3-column shift register is loaded on each ip_flag beat. It is valid when the accepted pixel has row>=2 and col>=2; its centre is (row-1, col-1).
- Kernels, with window rows t/m/b and columns l/c/r:
  - Gx = (tr + 2mr + br) - (tl + 2ml + bl)
  - Gy = (bl + 2bc + br) - (tl + 2tc + tr)
  - Both are signed, DW+4 bits wide; no overflow is possible.
- Absolute values are taken before summing. Sum S = |Gx|+|Gy| is unsigned, DW+3 bits.
- Output by mode:
  - 00, 10, 11: min(value, 2^DW-1).
  - 01: all-ones if S >= thresh, else 0.
- mode and thresh are sampled on the beat accepting pixel (0,0) and held for the whole frame. Mid-frame changes are ignored.
- Pipeline is fixed and does not stall. op_flag asserts exactly 4 tft_clk cycles after the ip_flag beat that completes a valid window, independent of input gaps.
  - Stage 1: line-buffer read and window shift.
  - Stage 2: Gx and Gy.
  - Stage 3: absolute values and sum.
  - Stage 4: mode mux and output register.
- Output counts: (PIC_W-2)*(PIC_H-2) op_flag beats per frame; no border pixels are emitted.
- Markers:
  - op_sof accompanies centre (1,1).
  - op_eol accompanies centre column PIC_W-2.
  - frame_done accompanies centre (PIC_H-2, PIC_W-2).
  - All markers are asserted only together with op_flag.
- Back-to-back frames with no gap are supported. Row 0 of the next frame may arrive while the last outputs of the previous frame are still in the pipeline.
- Reset mid-frame: immediate clear. The next accepted pixel is (0,0).

Optional Feature:
SOBEL_STATS_EN
- Defined: adds output edge_cnt [CW*2-1:0], reset 0.
  - An internal accumulator counts output pixels with S >= thresh, in every mode.
  - On frame_done the count, including the final pixel, is latched into edge_cnt and the accumulator is cleared.
  - edge_cnt updates in the same cycle frame_done is asserted.
- Undefined: no edge_cnt port and no accumulator logic.

Test Plan:
- PIC_W=8, PIC_H=6, DW=8, mode 00, flat frame of value 100, continuous ip_flag -> 24 op_flag beats, all op_data=0, op_sof once, op_eol 4 times, frame_done once on the 24th beat.
- Same geometry, columns 0-3=0 and 4-7=255, mode 00 -> in each output row, centre cols 3 and 4 =255 (Gx=1020 saturated), others 0. Mode 11 -> all 0. Mode 10 matches mode 00.
- Horizontal step (rows 0-2=0, rows 3-5=40), mode 01, thresh=160 -> centre rows 2 and 3 are 255 (S=160), others 0. Rerun with thresh=161 -> all 0.
- Vertical-step frame with random 0-3 cycle gaps on ip_flag -> op_data sequence identical to the gapless run; each op_flag exactly 4 cycles after its completing input beat.
- Mid-frame (after 20 pixels), assert ip_sof with ip_flag, then feed a full flat frame -> exactly 24 outputs with op_sof on the first. Change mode at pixel 10 -> no effect until the next frame.
- Assert tft_rst for 1 cycle mid-frame -> outputs 0 immediately, then a clean full frame follows. With SOBEL_STATS_EN, the vertical-step frame in mode 01 with thresh=100 -> edge_cnt=8 at frame_done.
